// File: rtl/uart_frame_tx.sv
// uart_frame_tx
// Transmit-side framer for the debug link. Streams a dump of up to MAX_WORDS
// 32-bit words into the UART TX FIFO as:
//   HEADER, word count, words (MSB first), XOR checksum of all prior bytes.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        asynchronous, active-low reset (aborts any frame in flight)
//   I_START      one-cycle frame request, honoured only in IDLE
//   I_NUM_WORDS  requested word count, sampled with I_START, clamped to MAX_WORDS
//   O_WORD_IDX   index presented to the external word-source mux
//   I_WORD       word selected by O_WORD_IDX, valid in the same cycle
//   I_TX_FULL    UART TX FIFO full
//   O_WR_UART    byte write strobe into the UART TX FIFO
//   O_DATA_UART  byte being written, valid with O_WR_UART
//   O_BUSY       high while a frame is in progress (through the DONE cycle)
//   O_DONE       one-cycle pulse after the checksum byte has been written
module uart_frame_tx #(
  parameter int         MAX_WORDS = 128,
  parameter int         IDX_W     = 7,
  parameter logic [7:0] HEADER    = 8'hA5
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_START,
  input  logic [7:0]       I_NUM_WORDS,
  output logic [IDX_W-1:0] O_WORD_IDX,
  input  logic [31:0]      I_WORD,
  input  logic             I_TX_FULL,
  output logic             O_WR_UART,
  output logic [7:0]       O_DATA_UART,
  output logic             O_BUSY,
  output logic             O_DONE
);

  typedef enum logic [2:0] {
    IDLE, HDR, CNT, FETCH, BYTE, CHK, DONE
  } state_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       byteCnt_q, byteCnt_d;
  logic [31:0]      wordReg_q, wordReg_d;
  logic [7:0]       chk_q, chk_d;
  logic [7:0]       count_q, count_d;

  logic             wrUart;
  logic [7:0]       dataUart;
  logic [7:0]       clampedCount;
  logic             lastWord;

  assign clampedCount = (I_NUM_WORDS > MAX_CNT) ? MAX_CNT : I_NUM_WORDS;
  assign lastWord     = (8'(idx_q) == (count_q - 8'd1));

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      byteCnt_q <= '0;
      wordReg_q <= '0;
      chk_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      byteCnt_q <= byteCnt_d;
      wordReg_q <= wordReg_d;
      chk_q     <= chk_d;
      count_q   <= count_d;
    end
  end

  // Next-state logic. Every sending state advances only in a cycle where the
  // byte is actually written (wrUart), so backpressure simply freezes the FSM.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    byteCnt_d = byteCnt_q;
    wordReg_d = wordReg_q;
    chk_d     = chk_q;
    count_d   = count_q;

    if (wrUart) begin
      chk_d = chk_q ^ dataUart;
    end

    case (state_q)
      IDLE: begin
        if (I_START) begin
          count_d = clampedCount;
          chk_d   = '0;
          idx_d   = '0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (wrUart) state_d = CNT;
      end
      CNT: begin
        if (wrUart) begin
          if (count_q == 8'd0) begin
            state_d = CHK;
          end else begin
            idx_d   = '0;
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        wordReg_d = I_WORD;
        byteCnt_d = '0;
        state_d   = BYTE;
      end
      BYTE: begin
        if (wrUart) begin
          wordReg_d = {wordReg_q[23:0], 8'h00};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            if (lastWord) begin
              state_d = CHK;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
      end
      CHK: begin
        if (wrUart) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. The byte comes from registered state only; the strobe is the
  // combinational inverse of FIFO-full in the sending states.
  always_comb begin
    wrUart   = 1'b0;
    dataUart = 8'h00;
    case (state_q)
      HDR: begin
        wrUart   = ~I_TX_FULL;
        dataUart = HEADER;
      end
      CNT: begin
        wrUart   = ~I_TX_FULL;
        dataUart = count_q;
      end
      BYTE: begin
        wrUart   = ~I_TX_FULL;
        dataUart = wordReg_q[31:24];
      end
      CHK: begin
        wrUart   = ~I_TX_FULL;
        dataUart = chk_q;
      end
      default: begin
        wrUart   = 1'b0;
        dataUart = 8'h00;
      end
    endcase
  end

  assign O_WR_UART   = wrUart;
  assign O_DATA_UART = dataUart;
  assign O_WORD_IDX  = idx_q;
  assign O_BUSY      = (state_q != IDLE);
  assign O_DONE      = (state_q == DONE);

endmodule
